// File: rtl/mem_1kb_loader_if.sv
// Bus bundle for the 1 KB RAM loader: start/config, byte stream handshake,
// status outputs and the external read port.
interface mem_1kb_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   wr_count;
  logic [DATA_W-1:0] checksum;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output start, base_addr, length, in_valid, in_data, rd_addr,
    input  in_ready, busy, done, err, wr_count, checksum, rd_data
  );

  modport slave (
    input  start, base_addr, length, in_valid, in_data, rd_addr,
    output in_ready, busy, done, err, wr_count, checksum, rd_data
  );
endinterface

// File: rtl/mem_1kb_loader.sv
// 1024x8 RAM with a stream loader FSM that writes a wrapping address window,
// then re-reads it to confirm the checksum. Separate registered external read port.
module mem_1kb_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  mem_1kb_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [ADDR_W:0]   vcnt_q, vcnt_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] vsum_q, vsum_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic              vvalid_q, vvalid_d;
  logic [DATA_W-1:0] vrd_data_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              hs_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] vaddr_s;
  logic [DATA_W-1:0] final_sum_s;

  // in_ready is a flop that is only high in WRITE, so a handshake implies WRITE.
  assign hs_s        = in_ready_q & bus.in_valid;
  assign wr_en_s     = hs_s & ~rst;
  assign vaddr_s     = base_q + vcnt_q[ADDR_W-1:0];
  assign final_sum_s = vsum_q + vrd_data_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cur_addr_d = cur_addr_q;
    len_d      = len_q;
    wr_count_d = wr_count_q;
    checksum_d = checksum_q;
    vcnt_d     = vcnt_q;
    vsum_d     = vsum_q;
    err_d      = err_q;
    vvalid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d     = bus.base_addr;
          cur_addr_d = bus.base_addr;
          len_d      = bus.length;
          wr_count_d = '0;
          checksum_d = '0;
          vcnt_d     = '0;
          vsum_d     = '0;
          err_d      = 1'b0;
          if (bus.length == '0) begin
            state_d = S_DONE;
          end else if (bus.length > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        if (hs_s) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
          checksum_d = checksum_q + bus.in_data;
          if (wr_count_q + (ADDR_W + 1)'(1) == len_q) begin
            state_d = S_VERIFY;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      // Issue addresses for vcnt 0..len-1; the extra cycle at vcnt==len
      // absorbs the last read's latency before the compare.
      S_VERIFY: begin
        if (vvalid_q) begin
          vsum_d = vsum_q + vrd_data_q;
        end else begin
          vsum_d = vsum_q;
        end
        if (vcnt_q == len_q) begin
          state_d = S_DONE;
          if (final_sum_s != checksum_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          vcnt_d   = vcnt_q + (ADDR_W + 1)'(1);
          vvalid_d = 1'b1;
          state_d  = S_VERIFY;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    in_ready_d = (state_d == S_WRITE);
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      cur_addr_q <= '0;
      len_q      <= '0;
      wr_count_q <= '0;
      checksum_q <= '0;
      vcnt_q     <= '0;
      vsum_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      vvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      wr_count_q <= wr_count_d;
      checksum_q <= checksum_d;
      vcnt_q     <= vcnt_d;
      vsum_q     <= vsum_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      vvalid_q   <= vvalid_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[cur_addr_q] <= bus.in_data;
    end
  end

  // Internal verify read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      vrd_data_q <= '0;
    end else begin
      vrd_data_q <= mem[vaddr_s];
    end
  end

  // External read port; a same-cycle write to rd_addr returns the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.wr_count = wr_count_q;
  assign bus.checksum = checksum_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_1kb_loader.sv
// Self-checking bench for mem_1kb_loader: directed table, hand sequences for
// reset/abort, and randomized loads against an array-based memory model.
module tb_mem_1kb_loader;

  logic clk;
  logic rst;

  mem_1kb_loader_if bus ();

  mem_1kb_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    logic [31:0] data;
    int          mode;
    logic [10:0] exp_cnt;
    logic [7:0]  exp_sum;
    logic        exp_err;
  } load_rec_t;

  int          n_tests;
  int          n_fail;
  logic [7:0]  ref_mem   [1024];
  logic        ref_known [1024];
  logic [7:0]  stim      [1024];
  load_rec_t   recs      [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic readback(input logic [9:0] a);
    bus.rd_addr = a;
    @(negedge clk);
    if (ref_known[a]) check("rd_data", {24'd0, bus.rd_data}, {24'd0, ref_mem[a]});
  endtask

  // mode 0: in_valid always high; 1: random gaps; 2: fixed gap pattern 1,0,0,1,0,1.
  task automatic do_load(input logic [9:0] b, input logic [10:0] l, input int mode,
                         input logic [10:0] exp_cnt, input logic [7:0] exp_sum, input logic exp_err);
    int         beats;
    int         it;
    int         lat;
    logic       hs;
    logic [9:0] a;
    logic [7:0] old;
    logic       old_known;
    logic [5:0] pat;
    pat = 6'b101001;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.length    = l;
    @(negedge clk);
    bus.start = 1'b0;
    beats = 0;
    it    = 0;
    if (l != 11'd0 && l <= 11'd1024) begin
      while (beats < int'(l) && it < 20000) begin
        a = b + beats[9:0];
        if (mode == 2 && it < 6) bus.in_valid = pat[it];
        else if (mode == 1)      bus.in_valid = ($urandom_range(99) >= 30);
        else                     bus.in_valid = 1'b1;
        bus.in_data = stim[beats];
        bus.rd_addr = a;
        // A start while busy must be ignored.
        bus.start     = (mode != 2 && beats == 1);
        bus.base_addr = ~b;
        bus.length    = 11'd5;
        hs        = bus.in_valid && bus.in_ready;
        old       = ref_mem[a];
        old_known = ref_known[a];
        @(negedge clk);
        bus.start = 1'b0;
        it++;
        if (hs) begin
          if (old_known) check("rd_old_on_write", {24'd0, bus.rd_data}, {24'd0, old});
          ref_mem[a]   = stim[beats];
          ref_known[a] = 1'b1;
          beats++;
          check("wr_count_step", {21'd0, bus.wr_count}, beats);
        end
      end
      bus.in_valid = 1'b0;
      check("write_beats", beats, {21'd0, l});
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, (l == 11'd0 || l > 11'd1024) ? 0 : int'(l) + 1);
    check("wr_count", {21'd0, bus.wr_count}, {21'd0, exp_cnt});
    check("checksum", {24'd0, bus.checksum}, {24'd0, exp_sum});
    check("err", {31'd0, bus.err}, {31'd0, exp_err});
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic random_load(input logic [10:0] l, input int mode);
    logic [9:0] b;
    logic [7:0] s;
    b = 10'($urandom);
    s = 8'd0;
    for (int i = 0; i < int'(l); i++) begin
      stim[i] = 8'($urandom);
      s       = s + stim[i];
    end
    do_load(b, l, mode, l, s, 1'b0);
    for (int i = 0; i < 6; i++) readback(b + 10'(i));
    for (int i = 0; i < 4; i++) readback(10'($urandom));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = 8'd0;
      ref_known[i] = 1'b0;
    end
    recs[0] = '{base: 10'h000, len: 11'd4,    data: 32'h01FF3CA5, mode: 0, exp_cnt: 11'd4, exp_sum: 8'hE1, exp_err: 1'b0};
    recs[1] = '{base: 10'h3FE, len: 11'd4,    data: 32'h44332211, mode: 0, exp_cnt: 11'd4, exp_sum: 8'hAA, exp_err: 1'b0};
    recs[2] = '{base: 10'h050, len: 11'd3,    data: 32'h00302010, mode: 2, exp_cnt: 11'd3, exp_sum: 8'h60, exp_err: 1'b0};
    recs[3] = '{base: 10'h120, len: 11'd0,    data: 32'h0,        mode: 0, exp_cnt: 11'd0, exp_sum: 8'h00, exp_err: 1'b0};
    recs[4] = '{base: 10'h120, len: 11'd1100, data: 32'h0,        mode: 0, exp_cnt: 11'd0, exp_sum: 8'h00, exp_err: 1'b1};
    recs[5] = '{base: 10'h120, len: 11'd0,    data: 32'h0,        mode: 0, exp_cnt: 11'd0, exp_sum: 8'h00, exp_err: 1'b0};

    bus.start     = 1'b0;
    bus.base_addr = 10'd0;
    bus.length    = 11'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.rd_addr   = 10'd0;

    // Reset: two cycles, outputs cleared.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_wr_count", {21'd0, bus.wr_count}, 32'd0);
    check("rst_checksum", {24'd0, bus.checksum}, 32'd0);
    rst = 1'b0;

    // Full 1024-byte window: every location written once.
    random_load(11'd1024, 0);

    // Directed table.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] d;
      d = recs[r].data;
      for (int i = 0; i < 4; i++) stim[i] = d[8*i +: 8];
      do_load(recs[r].base, recs[r].len, recs[r].mode, recs[r].exp_cnt, recs[r].exp_sum, recs[r].exp_err);
      for (int i = 0; i < 4; i++) readback(recs[r].base + 10'(i));
    end

    // Reset mid-write after 2 of 4 beats.
    stim[0] = 8'h5A;
    stim[1] = 8'hC3;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = 10'h200;
    bus.length    = 11'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      @(negedge clk);
      ref_mem[10'h200 + 10'(i)]   = stim[i];
      ref_known[10'h200 + 10'(i)] = 1'b1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("abort_idle_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) readback(10'h200 + 10'(i));

    // Randomized loads with gaps and wrap.
    for (int n = 0; n < 6; n++) random_load(11'($urandom_range(40, 1)), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
